// File: rtl/bin2bcd_sampler.sv
// bin2bcd_sampler
//   Periodically snapshots a binary value and converts it to packed BCD with a
//   sequential double-dabble (correct-then-shift, one input bit per clock).
//   A free-running sample timer raises an automatic trigger every SAMPLE_DIV
//   cycles. A level-sampled start request also triggers. Triggers that arrive
//   while a conversion is running collapse into a single pending request.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   en_i     in   enables the sample timer and all triggers
//   start_i  in   manual conversion request (level, sampled each cycle)
//   bin_i    in   [IN_W-1:0] binary value, captured on the trigger edge
//   bcd_o    out  [4*DIGITS-1:0] packed BCD result, digit 0 in [3:0]
//   valid_o  out  one-cycle pulse when bcd_o updates
//   busy_o   out  conversion in progress (state != IDLE)
//
// Handshake: valid_o is a one-cycle pulse with no ready; bcd_o is stable from
// that pulse until the next one and never shows a partial result.
module bin2bcd_sampler #(
   parameter int IN_W       = 18,
   parameter int DIGITS     = 6,
   parameter int SAMPLE_DIV = 10_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  start_i,
   input  logic [IN_W-1:0]       bin_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  valid_o,
   output logic                  busy_o
);

   localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CW = $clog2(IN_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(IN_W - 1);

   logic [1:0]            state;
   logic [TW-1:0]         timer;
   logic                  pending;
   logic [CW-1:0]         bit_cnt;
   logic [IN_W-1:0]       shift_q;
   logic [4*DIGITS-1:0]   scratch;

   logic                  tick;
   logic                  req;
   logic                  trigger;
   logic [4*DIGITS-1:0]   corrected;
   logic [4*DIGITS-1:0]   scratch_next;
   logic [IN_W-1:0]       shift_next;

   assign tick    = (timer == TIMER_LAST);
   // req is a fresh request this cycle; trigger also covers a queued one.
   assign req     = en_i & (tick | start_i);
   assign trigger = req | (en_i & pending);
   assign busy_o  = (state != S_IDLE);

   // Add 3 to every digit >= 5 so the following left shift carries into the
   // next decimal digit instead of producing a nibble value of 10..15.
   always_comb begin
      corrected = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            corrected[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
   end

   // Scratch and shift register move as one wide register: the MSB of the
   // binary value enters the LSB of digit 0.
   assign {scratch_next, shift_next} = {corrected, shift_q} << 1;

   // Sample timer: held at 0 while disabled, otherwise wraps at SAMPLE_DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (!en_i || tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // Pending request: armed by requests seen while busy, consumed in IDLE
   // (where trigger is necessarily true if pending was set), dropped on disable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (!en_i) begin
         pending <= 1'b0;
      end else if (state == S_IDLE) begin
         pending <= 1'b0;
      end else if (req) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shift_q <= '0;
         scratch <= '0;
         bcd_o   <= '0;
         valid_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               valid_o <= 1'b0;
               if (trigger) begin
                  shift_q <= bin_i;
                  scratch <= '0;
                  bit_cnt <= '0;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               scratch <= scratch_next;
               shift_q <= shift_next;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  // Last shift: publish the finished digits directly.
                  bcd_o   <= scratch_next;
                  valid_o <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               valid_o <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               valid_o <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_sampler.sv
// tb_bin2bcd_sampler
//   Bench for bin2bcd_sampler with IN_W=18, DIGITS=6, SAMPLE_DIV=64.
//   A reference model predicts valid_o/busy_o/bcd_o every cycle from the
//   behavioural rules (countdown of busy cycles, decimal digits by % and /);
//   directed scenarios add explicit constant expectations.
module tb_bin2bcd_sampler;

   localparam int IN_W       = 18;
   localparam int DIGITS     = 6;
   localparam int SAMPLE_DIV = 64;
   localparam int BW         = 4 * DIGITS;

   logic            clk;
   logic            rst;
   logic            en_i;
   logic            start_i;
   logic [IN_W-1:0] bin_i;
   logic [BW-1:0]   bcd_o;
   logic            valid_o;
   logic            busy_o;

   int n_cmp = 0;
   int n_err = 0;
   logic chk_on = 1'b0;

   bin2bcd_sampler #(
      .IN_W       (IN_W),
      .DIGITS     (DIGITS),
      .SAMPLE_DIV (SAMPLE_DIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en_i),
      .start_i (start_i),
      .bin_i   (bin_i),
      .bcd_o   (bcd_o),
      .valid_o (valid_o),
      .busy_o  (busy_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] to_bcd(input int unsigned v);
      logic [BW-1:0] r;
      int unsigned   x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // ---------------- reference model ----------------
   // m_rem counts the busy cycles still ahead (IN_W+1 after a trigger);
   // the result appears when one busy cycle remains.
   int            m_timer;
   int            m_rem;
   logic          m_pend;
   int unsigned   m_cap;
   logic          m_valid;
   logic [BW-1:0] m_bcd;
   logic          m_tick;
   logic          m_req;

   assign m_tick = (m_timer == SAMPLE_DIV - 1);
   assign m_req  = en_i && (m_tick || start_i);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_timer <= 0;
         m_rem   <= 0;
         m_pend  <= 1'b0;
         m_cap   <= 0;
         m_valid <= 1'b0;
         m_bcd   <= '0;
      end else begin
         m_valid <= 1'b0;
         if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
               m_bcd   <= to_bcd(m_cap);
               m_valid <= 1'b1;
            end
            if (m_req) m_pend <= 1'b1;
         end else if (m_req || (en_i && m_pend)) begin
            m_cap  <= int'(bin_i);
            m_rem  <= IN_W + 1;
            m_pend <= 1'b0;
         end
         if (!en_i) m_pend <= 1'b0;
         m_timer <= (!en_i || m_tick) ? 0 : m_timer + 1;
      end
   end

   // Scoreboard compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check_eq("valid_o", 32'(valid_o), 32'(m_valid));
         check_eq("busy_o", 32'(busy_o), 32'(m_rem != 0));
         check_eq("bcd_o", 32'(bcd_o), 32'(m_bcd));
      end
   end

   // ---------------- driver tasks ----------------
   // Idle with the timer cleared; returns with en_i=1 at a falling edge, so
   // the next rising edge moves the timer 0 -> 1.
   task automatic quiesce();
      en_i    = 1'b0;
      start_i = 1'b0;
      repeat (IN_W + 4) @(negedge clk);
      en_i = 1'b1;
   endtask

   // One manual conversion of v; bin_i becomes alt right after the trigger edge.
   // lat = falling edges from the trigger edge to valid_o (0 if never seen).
   task automatic run_one(input logic [IN_W-1:0] v, input logic [IN_W-1:0] alt,
                          output int lat, output logic [BW-1:0] got, output int busy_n);
      quiesce();
      bin_i   = v;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      bin_i   = alt;
      lat     = 0;
      busy_n  = 0;
      got     = '0;
      for (int i = 1; i <= IN_W + 12; i++) begin
         if (i > 1) @(negedge clk);
         if (busy_o) busy_n++;
         if (valid_o && lat == 0) begin
            lat = i;
            got = bcd_o;
         end
      end
   endtask

   // Count valid_o pulses over n falling edges.
   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (valid_o) cnt++;
      end
   endtask

   logic [IN_W-1:0] t3_v [5] = '{18'd0, 18'd9, 18'd10, 18'd99999, 18'd100000};
   logic [BW-1:0]   t3_e [5] = '{24'h000000, 24'h000009, 24'h000010, 24'h099999, 24'h100000};

   // ---------------- stimulus ----------------
   initial begin
      int            lat;
      int            busy_n;
      int            cnt;
      int            cyc;
      logic [BW-1:0] got;
      int            vq[$];

      rst     = 1'b0;
      en_i    = 1'b0;
      start_i = 1'b0;
      bin_i   = '0;
      #1 rst = 1'b1;

      // 1) reset with arbitrary inputs, then automatic sampling only.
      for (int i = 0; i < 3; i++) begin
         en_i    = 1'($urandom_range(0, 1));
         start_i = 1'($urandom_range(0, 1));
         bin_i   = IN_W'($urandom);
         @(negedge clk);
         check_eq("rst_bcd", 32'(bcd_o), 32'd0);
         check_eq("rst_valid", 32'(valid_o), 32'd0);
         check_eq("rst_busy", 32'(busy_o), 32'd0);
      end
      rst     = 1'b0;
      en_i    = 1'b1;
      start_i = 1'b0;
      bin_i   = 18'd4242;
      chk_on  = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!valid_o && cyc < 200);
      // tick at timer 63 -> trigger on rising edge 64 -> result after edge 64+18
      // (the 83rd cycle counting the release cycle as the first).
      check_eq("auto_first_valid", 32'(cyc), 32'(SAMPLE_DIV + IN_W));
      check_eq("auto_bcd", 32'(bcd_o), 32'h004242);

      // 2) full-scale value.
      run_one(18'h3FFFF, IN_W'($urandom), lat, got, busy_n);
      check_eq("max_latency", 32'(lat), 32'(IN_W + 1));
      check_eq("max_bcd", 32'(got), 32'h262143);
      check_eq("max_busy_cycles", 32'(busy_n), 32'(IN_W + 1));

      // 3) decimal boundaries.
      for (int k = 0; k < 5; k++) begin
         run_one(t3_v[k], IN_W'($urandom), lat, got, busy_n);
         check_eq("seq_latency", 32'(lat), 32'(IN_W + 1));
         check_eq("seq_bcd", 32'(got), 32'(t3_e[k]));
      end

      // 4) input change right after the trigger edge is not seen.
      run_one(18'd1234, 18'd5678, lat, got, busy_n);
      check_eq("capture_bcd", 32'(got), 32'h001234);

      // 5a) start held high: back-to-back conversions every IN_W+2 cycles.
      quiesce();
      bin_i   = 18'd777;
      start_i = 1'b1;
      vq.delete();
      for (int i = 1; i <= 62; i++) begin
         @(negedge clk);
         if (valid_o) vq.push_back(i);
      end
      start_i = 1'b0;
      check_eq("held_count", 32'(vq.size()), 32'd3);
      if (vq.size() >= 3) begin
         check_eq("held_period_a", 32'(vq[1] - vq[0]), 32'(IN_W + 2));
         check_eq("held_period_b", 32'(vq[2] - vq[1]), 32'(IN_W + 2));
      end

      // 5b) extra requests while busy collapse into one follow-up.
      quiesce();
      bin_i   = 18'd31;
      start_i = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         start_i = (i == 5 || i == 10);
         if (valid_o) cnt++;
      end
      check_eq("pending_collapse", 32'(cnt), 32'd2);

      // 5c) tick and start in the same cycle give a single conversion.
      quiesce();
      repeat (SAMPLE_DIV - 1) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      count_valid(50, cnt);
      check_eq("tick_start_single", 32'(cnt), 32'd1);

      // en_i dropped mid-conversion: it finishes, the queued request is lost.
      quiesce();
      bin_i   = 18'd500;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      repeat (4) @(negedge clk);
      start_i = 1'b0;
      en_i    = 1'b0;
      count_valid(50, cnt);
      check_eq("disable_midconv", 32'(cnt), 32'd1);
      check_eq("disable_bcd", 32'(bcd_o), 32'h000500);

      // 6) asynchronous reset while shifting bit 7.
      quiesce();
      bin_i   = 18'd200000;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_bcd", 32'(bcd_o), 32'd0);
      check_eq("arst_busy", 32'(busy_o), 32'd0);
      check_eq("arst_valid", 32'(valid_o), 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      en_i = 1'b1;
      count_valid(40, cnt);
      check_eq("arst_no_valid", 32'(cnt), 32'd0);
      run_one(18'd65535, 18'd1, lat, got, busy_n);
      check_eq("arst_recover_bcd", 32'(got), 32'h065535);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         en_i    = ($urandom_range(0, 15) != 0);
         start_i = ($urandom_range(0, 9) == 0);
         bin_i   = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : IN_W'($urandom);
      end
      en_i    = 1'b0;
      start_i = 1'b0;
      repeat (IN_W + 4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
